timer_preset_loader: RTL and testbench

- Producer side of the timer-chain load interface: collects keypad digits into an M:SS preset, then drives the parallel-load data and active-low load strobe into the minutes, tens (mod-6) and ones counters.
- Gates the count enable during cooking and watches the chain's zero flag to end the cycle.
- Sits between the keypad decoder and the timer chain in the microwave top level.

---
 rtl/timer_preset_loader_pkg.sv | 19 +
 rtl/timer_preset_loader_bcd_shift3.sv | 63 ++++++
 rtl/timer_preset_loader.sv | 184 ++++++++++++++++++
 tb/tb_timer_preset_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_preset_loader_pkg.sv
// Shared timer definitions: controller state encoding, default digit width,
// largest legal tens-of-seconds digit and the BCD max digit.
// Also used by the timer-chain counter modules.
package timer_preset_loader_pkg;

    localparam int unsigned TMR_DIGIT_W   = 4;
    localparam int unsigned TMR_MAX_TENS  = 5;
    localparam int unsigned BCD_MAX_DIGIT = 9;
    localparam int unsigned LOAD_CNT_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4
    } tmr_state_e;

endpackage

// File: rtl/timer_preset_loader_bcd_shift3.sv
// 3-digit BCD shift register holding the M:SS preset.
// Ports:
//   clk, clrn        clock, async active-low reset
//   clr_i            synchronous clear of all digits (wins over shift)
//   shift_i          shift enable; a digit shifts in only when it is legal
//   digit_i          incoming keypad digit
//   digit_legal_c_o  combinational: digit_i is 0..9
//   mins_o/tens_o/ones_o  registered digits
module timer_preset_loader_bcd_shift3
    import timer_preset_loader_pkg::*;
#(
    parameter int unsigned DIGIT_W = TMR_DIGIT_W
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic               digit_legal_c_o,
    output logic [DIGIT_W-1:0] mins_o,
    output logic [DIGIT_W-1:0] tens_o,
    output logic [DIGIT_W-1:0] ones_o
);

    logic [DIGIT_W-1:0] mins_q, mins_d;
    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;

    assign digit_legal_c_o = (digit_i <= DIGIT_W'(BCD_MAX_DIGIT));

    // Next digits: clear, or shift left with the old minutes digit discarded
    always_comb begin
        mins_d = mins_q;
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            mins_d = '0;
            tens_d = '0;
            ones_d = '0;
        end else if (shift_i && digit_legal_c_o) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = digit_i;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mins_q <= '0;
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            mins_q <= mins_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign mins_o = mins_q;
    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: rtl/timer_preset_loader.sv
// Keypad-to-timer-chain preset loader: collects digits into an M:SS preset,
// pulses the active-low parallel load, gates the count enable and ends the
// cook on the chain's zero flag.
// Ports:
//   clk, clrn                       clock, async active-low reset
//   key_valid, key_digit            keypad digit strobe and value
//   start, stop, cancel             operator requests
//   timer_zero                      chain reports 0:00
//   mins_data, tens_data, ones_data preset digits to the counter loads
//   loadn                           active-low load strobe
//   en                              count enable
//   busy                            high in LOAD, RUN or PAUSE
//   done, err                       one-cycle end-of-cook / rejected-start pulses
// Build option: define TIME_LOADER_AUTOCLR_EN to clear the preset when a cook
// ends on timer_zero; otherwise the preset is retained for re-entry.
module timer_preset_loader
    import timer_preset_loader_pkg::*;
#(
    parameter int unsigned DIGIT_W      = TMR_DIGIT_W,
    parameter int unsigned MAX_TENS     = TMR_MAX_TENS,
    parameter int unsigned LOADN_CYCLES = 1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               start,
    input  logic               stop,
    input  logic               cancel,
    input  logic               timer_zero,
    output logic [DIGIT_W-1:0] mins_data,
    output logic [DIGIT_W-1:0] tens_data,
    output logic [DIGIT_W-1:0] ones_data,
    output logic               loadn,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               err
);

`ifdef TIME_LOADER_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    localparam logic [LOAD_CNT_W-1:0] LAST_LOAD = LOAD_CNT_W'(LOADN_CYCLES - 1);

    tmr_state_e            state_q, state_d;
    logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic                  first_q, first_d;
    logic                  loadn_q, loadn_d;
    logic                  en_q, en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  clr_c;
    logic                  shift_c;
    logic                  digit_legal_c;
    logic                  preset_zero_c;
    logic                  tens_bad_c;

    timer_preset_loader_bcd_shift3 #(
        .DIGIT_W (DIGIT_W)
    ) u_bcd_shift3 (
        .clk             (clk),
        .clrn            (clrn),
        .clr_i           (clr_c),
        .shift_i         (shift_c),
        .digit_i         (key_digit),
        .digit_legal_c_o (digit_legal_c),
        .mins_o          (mins_data),
        .tens_o          (tens_data),
        .ones_o          (ones_data)
    );

    assign preset_zero_c = (mins_data == '0) && (tens_data == '0) && (ones_data == '0);
    assign tens_bad_c    = (tens_data > DIGIT_W'(MAX_TENS));

    // Next state, digit control and registered-output decode
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        first_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        clr_c      = 1'b0;
        shift_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid && digit_legal_c) begin
                    shift_c = 1'b1;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (cancel) begin
                    clr_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (start) begin
                    // A key arriving with start is dropped
                    if (preset_zero_c || tens_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD;
                        load_cnt_d = '0;
                    end
                end else if (key_valid && digit_legal_c) begin
                    shift_c = 1'b1;
                end
            end
            ST_LOAD: begin
                if (cancel) begin
                    clr_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (load_cnt_q == LAST_LOAD) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end else begin
                    load_cnt_d = load_cnt_q + LOAD_CNT_W'(1);
                end
            end
            ST_RUN: begin
                // first_q masks timer_zero while the chain settles after load
                if (cancel) begin
                    clr_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_zero && !first_q) begin
                    done_d  = 1'b1;
                    clr_c   = AUTOCLR;
                    state_d = ST_IDLE;
                end else if (stop) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (cancel) begin
                    clr_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        loadn_d = (state_d != ST_LOAD);
        en_d    = (state_d == ST_RUN);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            first_q    <= 1'b0;
            loadn_q    <= 1'b1;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            first_q    <= first_d;
            loadn_q    <= loadn_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign loadn = loadn_q;
    assign en    = en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_timer_preset_loader.sv
// Bench for timer_preset_loader: two instances (load strobe of 1 and 3 cycles)
// share one stimulus stream and are compared every cycle against a
// behavioural model of the operator-level rules, plus directed scenarios with
// literal expectations.
module tb_timer_preset_loader;

    localparam int unsigned DW = 4;
    localparam int MAXT = 5;

`ifdef TIME_LOADER_AUTOCLR_EN
    localparam bit AUTOCLR = 1'b1;
`else
    localparam bit AUTOCLR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          key_valid = 1'b0;
    logic [DW-1:0] key_digit = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cancel = 1'b0;
    logic          timer_zero = 1'b0;

    logic [DW-1:0] mins_w [2];
    logic [DW-1:0] tens_w [2];
    logic [DW-1:0] ones_w [2];
    logic          loadn_w [2];
    logic          en_w [2];
    logic          busy_w [2];
    logic          done_w [2];
    logic          err_w [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_preset_loader #(.DIGIT_W(DW), .MAX_TENS(MAXT), .LOADN_CYCLES(1)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .cancel(cancel), .timer_zero(timer_zero),
        .mins_data(mins_w[0]), .tens_data(tens_w[0]), .ones_data(ones_w[0]),
        .loadn(loadn_w[0]), .en(en_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    timer_preset_loader #(.DIGIT_W(DW), .MAX_TENS(MAXT), .LOADN_CYCLES(3)) dut3 (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .cancel(cancel), .timer_zero(timer_zero),
        .mins_data(mins_w[1]), .tens_data(tens_w[1]), .ones_data(ones_w[1]),
        .loadn(loadn_w[1]), .en(en_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    // Model: mode 0 idle, 1 entry, 2 load, 3 run, 4 pause
    int lc [2] = '{1, 3};
    int m_mode [2];
    int m_dig [2][3];
    int m_left [2];
    bit m_fresh [2];
    bit m_done [2];
    bit m_err [2];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_dig[k] = '{0, 0, 0};
            m_left[k] = 0;
            m_fresh[k] = 1'b0;
            m_done[k] = 1'b0;
            m_err[k] = 1'b0;
        end
    endfunction

    function automatic void model_clear(input int k);
        m_dig[k] = '{0, 0, 0};
        m_mode[k] = 0;
    endfunction

    function automatic void model_step(input int k);
        int kd;
        bit key_ok;
        bit was_fresh;
        kd = int'(key_digit);
        key_ok = key_valid && (kd <= 9);
        was_fresh = m_fresh[k];
        m_fresh[k] = 1'b0;
        m_done[k] = 1'b0;
        m_err[k] = 1'b0;
        case (m_mode[k])
            0: if (key_ok) begin
                m_dig[k] = '{m_dig[k][1], m_dig[k][2], kd};
                m_mode[k] = 1;
            end
            1: if (cancel) model_clear(k);
               else if (start) begin
                   if ((m_dig[k][0] + m_dig[k][1] + m_dig[k][2]) == 0 || m_dig[k][1] > MAXT)
                       m_err[k] = 1'b1;
                   else begin
                       m_mode[k] = 2;
                       m_left[k] = lc[k];
                   end
               end else if (key_ok) m_dig[k] = '{m_dig[k][1], m_dig[k][2], kd};
            2: if (cancel) model_clear(k);
               else begin
                   m_left[k]--;
                   if (m_left[k] == 0) begin
                       m_mode[k] = 3;
                       m_fresh[k] = 1'b1;
                   end
               end
            3: if (cancel) model_clear(k);
               else if (timer_zero && !was_fresh) begin
                   m_done[k] = 1'b1;
                   m_mode[k] = 0;
                   if (AUTOCLR) m_dig[k] = '{0, 0, 0};
               end else if (stop) m_mode[k] = 4;
            4: if (cancel) model_clear(k);
               else if (start) m_mode[k] = 3;
            default: m_mode[k] = 0;
        endcase
    endfunction

    task automatic compare(input int k);
        chk($sformatf("i%0d mins", k), int'(mins_w[k]), m_dig[k][0]);
        chk($sformatf("i%0d tens", k), int'(tens_w[k]), m_dig[k][1]);
        chk($sformatf("i%0d ones", k), int'(ones_w[k]), m_dig[k][2]);
        chk($sformatf("i%0d loadn", k), int'(loadn_w[k]), int'(m_mode[k] != 2));
        chk($sformatf("i%0d en", k), int'(en_w[k]), int'(m_mode[k] == 3));
        chk($sformatf("i%0d busy", k), int'(busy_w[k]), int'(m_mode[k] >= 2));
        chk($sformatf("i%0d done", k), int'(done_w[k]), int'(m_done[k]));
        chk($sformatf("i%0d err", k), int'(err_w[k]), int'(m_err[k]));
    endtask

    // Per-cycle compare against the model
    always @(posedge clk) begin
        if (!clrn) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
            #1;
            for (int k = 0; k < 2; k++) compare(k);
        end
    end

    task automatic drive(input bit kv, input int kd, input bit st, input bit sp,
                         input bit cn, input bit tz);
        key_valid = kv;
        key_digit = DW'(kd);
        start = st;
        stop = sp;
        cancel = cn;
        timer_zero = tz;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        drive(1, d, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        chk("reset loadn", int'(loadn_w[0]), 1);
        chk("reset busy", int'(busy_w[0]), 0);
        chk("reset en", int'(en_w[0]), 0);
        chk("reset mins", int'(mins_w[0]), 0);

        // 1:30 load and run
        key(1); key(3); key(0);
        drive(0, 0, 1, 0, 0, 0);
        chk("load loadn", int'(loadn_w[0]), 0);
        chk("load busy", int'(busy_w[0]), 1);
        chk("load en", int'(en_w[0]), 0);
        chk("load mins", int'(mins_w[0]), 1);
        chk("load tens", int'(tens_w[0]), 3);
        chk("load ones", int'(ones_w[0]), 0);
        idle(1);
        chk("run loadn", int'(loadn_w[0]), 1);
        chk("run en", int'(en_w[0]), 1);
        chk("run busy", int'(busy_w[0]), 1);
        chk("load3 loadn", int'(loadn_w[1]), 0);
        idle(3);

        // Async reset mid-run, checked before any clock edge
        #3 clrn = 1'b0;
        #1;
        chk("arst en", int'(en_w[0]), 0);
        chk("arst loadn", int'(loadn_w[0]), 1);
        chk("arst mins", int'(mins_w[0]), 0);
        chk("arst tens", int'(tens_w[0]), 0);
        chk("arst en3", int'(en_w[1]), 0);
        @(negedge clk);
        clrn = 1'b1;

        // 1:75 rejected
        key(1); key(7); key(5);
        drive(0, 0, 1, 0, 0, 0);
        chk("bad err", int'(err_w[0]), 1);
        chk("bad loadn", int'(loadn_w[0]), 1);
        chk("bad busy", int'(busy_w[0]), 0);
        chk("bad tens", int'(tens_w[0]), 7);
        chk("bad ones", int'(ones_w[0]), 5);
        idle(1);
        chk("bad err end", int'(err_w[0]), 0);
        drive(0, 0, 0, 0, 1, 0);

        // 2:00 run, pause, resume, finish
        key(2); key(0); key(0);
        drive(0, 0, 1, 0, 0, 0);
        idle(11);
        drive(0, 0, 0, 1, 0, 0);
        chk("pause en", int'(en_w[0]), 0);
        chk("pause busy", int'(busy_w[0]), 1);
        drive(0, 0, 1, 0, 0, 0);
        chk("resume en", int'(en_w[0]), 1);
        chk("resume loadn", int'(loadn_w[0]), 1);
        idle(2);
        drive(0, 0, 0, 0, 0, 1);
        chk("end done", int'(done_w[0]), 1);
        chk("end en", int'(en_w[0]), 0);
        chk("end busy", int'(busy_w[0]), 0);
        chk("end mins", int'(mins_w[0]), AUTOCLR ? 0 : 2);
        drive(0, 0, 1, 0, 0, 0);
        chk("end done off", int'(done_w[0]), 0);
        chk("idle start", int'(busy_w[0]), 0);

        // Illegal key, then key+start collision
        reset_pulse();
        @(negedge clk);
        key(12);
        chk("k12 busy", int'(busy_w[0]), 0);
        chk("k12 ones", int'(ones_w[0]), 0);
        key(5);
        drive(1, 4, 1, 0, 0, 0);
        chk("ks loadn", int'(loadn_w[0]), 0);
        chk("ks ones", int'(ones_w[0]), 5);
        chk("ks tens", int'(tens_w[0]), 0);

        // Cancel on load cycle 2 of the 3-cycle instance
        idle(1);
        chk("c3 loadn before", int'(loadn_w[1]), 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("c3 loadn", int'(loadn_w[1]), 1);
        chk("c3 busy", int'(busy_w[1]), 0);
        chk("c3 done", int'(done_w[1]), 0);
        chk("c3 ones", int'(ones_w[1]), 0);

        // 1:30 to zero
        key(1); key(3); key(0);
        drive(0, 0, 1, 0, 0, 0);
        idle(4);
        drive(0, 0, 0, 0, 0, 1);
        chk("z done", int'(done_w[0]), 1);
        chk("z mins", int'(mins_w[0]), AUTOCLR ? 0 : 1);
        chk("z tens", int'(tens_w[0]), AUTOCLR ? 0 : 3);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) reset_pulse();
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 11),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
